vga_sprite_compositor: RTL

VGA_SPRITE_COMPOSITOR -- requirements
Module: vga_sprite_compositor

---
 rtl/vga_sprite_compositor.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vga_sprite_compositor.sv
// vga_sprite_compositor: 640x480 VGA timing with N rectangular sprites over a background colour.
// Sprite state is double-buffered and reloaded only at end of frame.
// Optional sprite-overlap detection is enabled by defining VGA_SPRITE_COLLISION_EN.
module vga_sprite_compositor #(
    parameter int N_SPRITES = 4,
    parameter int HALF_W    = 25,
    parameter int SPRITE_H  = 60,
    parameter int CLK_DIV   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [12*N_SPRITES-1:0] sprite_x,
    input  logic [12*N_SPRITES-1:0] sprite_y,
    input  logic [12*N_SPRITES-1:0] sprite_color,
    input  logic [N_SPRITES-1:0]    sprite_en,
    input  logic [11:0]             bg_color,
    output logic                    hSync,
    output logic                    vSync,
    output logic [3:0]              VGA_R,
    output logic [3:0]              VGA_G,
    output logic [3:0]              VGA_B,
    output logic                    screen_ready,
    output logic                    collision
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0]           div_q, div_d;
    logic [9:0]              hcount_q, hcount_d, vcount_q, vcount_d;
    logic [12*N_SPRITES-1:0] sx_q, sy_q, sc_q;
    logic [N_SPRITES-1:0]    sen_q, hit;
    logic [11:0]             pix_q, pix_d;
    logic                    hs_q, hs_d, vs_q, vs_d;
    logic                    tick, eof, active;
    logic signed [12:0]      hc, vc;

    assign tick   = div_q == DW'(CLK_DIV - 1);
    assign eof    = tick && hcount_q == 10'd799 && vcount_q == 10'd524;
    assign active = hcount_q < 10'd640 && vcount_q < 10'd480;
    assign hc     = {3'b000, hcount_q};
    assign vc     = {3'b000, vcount_q};

    // Divider and raster counter next state; counters move only on pixel ticks
    always_comb begin
        div_d    = tick ? '0 : div_q + DW'(1);
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (tick) begin
            hcount_d = hcount_q == 10'd799 ? 10'd0 : hcount_q + 10'd1;
            if (hcount_q == 10'd799) vcount_d = vcount_q == 10'd524 ? 10'd0 : vcount_q + 10'd1;
        end
    end

    // Signed compare keeps regions near the origin clipped instead of wrapping around
    for (genvar g = 0; g < N_SPRITES; g++) begin : g_hit
        logic signed [12:0] x, y;
        assign x = {1'b0, sx_q[12*g +: 12]};
        assign y = {1'b0, sy_q[12*g +: 12]};
        assign hit[g] = sen_q[g] && hc >= x - 13'(HALF_W) && hc <= x + 13'(HALF_W)
                        && vc >= y - 13'(SPRITE_H) && vc <= y;
    end

    // Pixel colour and sync levels for the current counter position; lowest index wins
    always_comb begin
        pix_d = bg_color;
        for (int i = N_SPRITES - 1; i >= 0; i--) if (hit[i]) pix_d = sc_q[12*i +: 12];
        if (!active) pix_d = 12'h000;
        hs_d = !(hcount_q >= 10'd656 && hcount_q <= 10'd751);
        vs_d = !(vcount_q >= 10'd490 && vcount_q <= 10'd491);
    end

    // Timing state plus colour/sync output registers, all loaded on the same tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
            pix_q    <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
        end else begin
            div_q    <= div_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            if (tick) begin
                pix_q <= pix_d;
                hs_q  <= hs_d;
                vs_q  <= vs_d;
            end
        end
    end

    // Shadow copy of sprite inputs, refreshed only between frames
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sx_q  <= '0;
            sy_q  <= '0;
            sc_q  <= '0;
            sen_q <= '0;
        end else if (eof) begin
            sx_q  <= sprite_x;
            sy_q  <= sprite_y;
            sc_q  <= sprite_color;
            sen_q <= sprite_en;
        end
    end

`ifdef VGA_SPRITE_COLLISION_EN
    logic flag_q, coll_q, overlap;
    assign overlap = active && (hit & (hit - N_SPRITES'(1))) != '0;
    // Sticky overlap flag for the frame in progress, published at end of frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_q <= 1'b0;
            coll_q <= 1'b0;
        end else if (eof) begin
            coll_q <= flag_q;
            flag_q <= 1'b0;
        end else if (tick && overlap) begin
            flag_q <= 1'b1;
        end
    end
    assign collision = coll_q;
`else
    assign collision = 1'b0;
`endif

    assign {VGA_R, VGA_G, VGA_B} = pix_q;
    assign hSync                 = hs_q;
    assign vSync                 = vs_q;
    assign screen_ready          = eof;
endmodule
